// File: rtl/alu2_acc.sv
// Single-cycle two-operand ALU with a valid/ready handshake and a multi-beat
// accumulate opcode that emits one sum every ACC_LEN accepted ACC beats.
module alu2_acc #(
  parameter int WIDTH   = 32,
  parameter int ACC_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       config_sig,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int         SHW      = $clog2(WIDTH);
  localparam logic [4:0] OP_ACC   = 5'd13;
  localparam logic [7:0] LAST_CNT = 8'(ACC_LEN - 1);

  logic [WIDTH-1:0] r_acc;
  logic [7:0]       r_cnt;

  logic             w_accept;
  logic             w_xfer;
  logic             w_acc_last;
  logic [WIDTH-1:0] w_res_p0;
  logic [WIDTH-1:0] w_acc_sum_p0;

  function automatic logic [WIDTH-1:0] alu_op(input logic [4:0]       op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SHW-1:0]          sh;
    a_s    = a;
    b_s    = b;
    sh     = b[SHW-1:0];
    alu_op = '0;
    case (op)
      5'd0:  alu_op = a + b;
      5'd1:  alu_op = a - b;
      5'd2:  alu_op = a * b;
      5'd3:  alu_op = a & b;
      5'd4:  alu_op = a | b;
      5'd5:  alu_op = a ^ b;
      5'd6:  alu_op = a << sh;
      5'd7:  alu_op = a >> sh;
      5'd8:  alu_op = a;
      5'd9:  alu_op = b;
      5'd10: alu_op = a_s >>> sh;
      5'd11: alu_op = (a_s < b_s) ? WIDTH'(1) : '0;
      5'd12: alu_op = (a == b) ? WIDTH'(1) : '0;
      default: alu_op = '0;
    endcase
  endfunction

  assign in_ready     = !out_valid || out_ready;
  assign w_accept     = in_valid && in_ready;
  assign w_xfer       = out_valid && out_ready;
  assign w_acc_last   = (r_cnt == LAST_CNT);
  assign w_res_p0     = alu_op(config_sig, in0, in1);
  assign w_acc_sum_p0 = r_acc + in0;

  // Stage p0 -> output register: r_cnt == 0 is IDLE, anything else is ACCUM.
  always_ff @(posedge clk) begin
    if (reset) begin
      out0      <= '0;
      out_valid <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      if (config_sig == OP_ACC && !w_acc_last) begin
        r_acc <= w_acc_sum_p0;
        r_cnt <= r_cnt + 8'd1;
        if (w_xfer) out_valid <= 1'b0;
      end else begin
        // Final ACC beat or any other opcode: emit and drop any partial sum.
        out0      <= (config_sig == OP_ACC) ? w_acc_sum_p0 : w_res_p0;
        out_valid <= 1'b1;
        r_acc     <= '0;
        r_cnt     <= '0;
      end
    end else if (w_xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu2_acc.sv
// Directed bench for alu2_acc: opcode sweep, shift masking, accumulate,
// back-pressure, abort and reset behaviour, plus an ACC_LEN=1 instance.
module tb_alu2_acc;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  config_sig;
  logic [31:0] in0, in1;
  logic        in_valid;
  logic        in_ready, out_valid, out_ready;
  logic [31:0] out0;
  logic        one_in_ready, one_out_valid;
  logic [31:0] one_out0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu2_acc #(.WIDTH(32), .ACC_LEN(4)) u_dut (
    .clk(clk), .reset(reset), .config_sig(config_sig), .in0(in0), .in1(in1),
    .in_valid(in_valid), .in_ready(in_ready), .out0(out0),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  alu2_acc #(.WIDTH(32), .ACC_LEN(1)) u_one (
    .clk(clk), .reset(reset), .config_sig(config_sig), .in0(in0), .in1(in1),
    .in_valid(in_valid), .in_ready(one_in_ready), .out0(one_out0),
    .out_valid(one_out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    config_sig = op;
    in0        = a;
    in1        = b;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic op_chk(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    beat(op, a, b);
    chk({tag, "_val"}, out0, exp);
    chk({tag, "_vld"}, out_valid, 1'b1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    reset    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    config_sig = '0; in0 = '0; in1 = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_out0", out0, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_rdy", in_ready, 1);

    // ACC_LEN=1 instance passes in0 straight through on each ACC beat
    beat(5'd13, 32'd9, 32'd0);
    chk("len1_a", one_out0, 9);
    chk("len1_a_vld", one_out_valid, 1);
    beat(5'd13, 32'd3, 32'd0);
    chk("len1_b", one_out0, 3);
    do_reset();

    op_chk("add_wrap", 5'd0,  32'hFFFF_FFFF, 32'd1, 32'd0);
    op_chk("sub",      5'd1,  32'd5, 32'd7, 32'hFFFF_FFFE);
    op_chk("mul",      5'd2,  32'h0001_0000, 32'h0001_0001, 32'h0001_0000);
    op_chk("and",      5'd3,  32'hF0F0, 32'hFF00, 32'hF000);
    op_chk("or",       5'd4,  32'hF0F0, 32'hFF00, 32'hFFF0);
    op_chk("xor",      5'd5,  32'hF0F0, 32'hFF00, 32'h0FF0);
    op_chk("shl_mask", 5'd6,  32'd1, 32'd33, 32'd2);
    op_chk("shr",      5'd7,  32'h8000_0000, 32'd4, 32'h0800_0000);
    op_chk("pass0",    5'd8,  32'h1234, 32'h5678, 32'h1234);
    op_chk("pass1",    5'd9,  32'h1234, 32'h5678, 32'h5678);
    op_chk("sra",      5'd10, 32'h8000_0000, 32'd4, 32'hF800_0000);
    op_chk("slt_t",    5'd11, 32'hFFFF_FFFF, 32'd0, 32'd1);
    op_chk("slt_f",    5'd11, 32'd0, 32'hFFFF_FFFF, 32'd0);
    op_chk("eq_t",     5'd12, 32'd5, 32'd5, 32'd1);
    op_chk("eq_f",     5'd12, 32'd5, 32'd6, 32'd0);
    op_chk("bad_op",   5'd20, 32'd5, 32'd6, 32'd0);

    // Accumulate 1+2+3+4; earlier result drains during the first ACC beat
    beat(5'd13, 32'd1, 32'd0);
    chk("acc_b1_vld", out_valid, 0);
    beat(5'd13, 32'd2, 32'd0);
    beat(5'd13, 32'd3, 32'd0);
    chk("acc_b3_vld", out_valid, 0);
    beat(5'd13, 32'd4, 32'd0);
    chk("acc_sum", out0, 10);
    chk("acc_sum_vld", out_valid, 1);
    for (int i = 0; i < 4; i++) beat(5'd13, 32'd5, 32'd0);
    chk("acc_again", out0, 20);

    // Back-pressure: result holds, new beat waits, then appears without gap
    op_chk("bp_add", 5'd0, 32'd2, 32'd3, 32'd5);
    out_ready = 1'b0;
    #1;
    chk("bp_rdy_low", in_ready, 0);
    config_sig = 5'd0; in0 = 32'd10; in1 = 32'd20; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", out0, 5);
      chk("bp_hold_vld", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_high", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_new", out0, 30);
    chk("bp_new_vld", out_valid, 1);
    tick();
    chk("drain_vld", out_valid, 0);
    chk("drain_hold", out0, 30);

    // Abort a partial sum with a normal opcode
    beat(5'd13, 32'd5, 32'd0);
    beat(5'd13, 32'd6, 32'd0);
    op_chk("abort_add", 5'd0, 32'd1, 32'd1, 32'd2);
    for (int i = 0; i < 4; i++) beat(5'd13, 32'd1, 32'd0);
    chk("abort_acc", out0, 4);

    // Reset mid-accumulation discards the partial sum
    for (int i = 0; i < 3; i++) beat(5'd13, 32'd1, 32'd0);
    do_reset();
    chk("rst_acc_vld", out_valid, 0);
    chk("rst_acc_out0", out0, 0);
    for (int i = 0; i < 4; i++) beat(5'd13, 32'd1, 32'd0);
    chk("rst_acc_sum", out0, 4);

    // Reset with a stalled result
    op_chk("stall_add", 5'd0, 32'd7, 32'd8, 32'd15);
    out_ready = 1'b0;
    tick();
    do_reset();
    chk("rst_stall_vld", out_valid, 0);
    chk("rst_stall_out0", out0, 0);
    chk("rst_stall_rdy", in_ready, 1);
    out_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu2_acc.md
ALU2_ACC -- requirements
Module: alu2_acc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath width in bits (minimum 8, power of two).
REQ-002 The block SHALL have parameter ACC_LEN, default 4, giving the number of beats summed per accumulate result (range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port config_sig, input, 5 bits: the opcode, sampled only on an accepted beat.
REQ-006 The block SHALL have port in0, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port in1, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the operands and opcode are valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept a beat.
REQ-010 The block SHALL have port out0, output, WIDTH bits: the registered result.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out0 holds an unconsumed result.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream consumes out0.

Function
REQ-013 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-014 An accepted beat SHALL occur on a rising edge where in_valid && in_ready; an output transfer SHALL occur where out_valid && out_ready.
REQ-015 Latency SHALL be 1 cycle: for non-ACC opcodes, out0/out_valid update on the edge of the accepted beat.
REQ-016 Opcodes SHALL be: 0 add; 1 sub (in0-in1); 2 mul (low WIDTH bits of product); 3 and; 4 or; 5 xor; 6 shl; 7 logical shr; 8 pass in0; 9 pass in1; 10 arithmetic shr; 11 signed less-than (1 or 0); 12 equal (1 or 0); 13 ACC; all others give result 0 with out_valid=1.
REQ-017 Shift amounts SHALL use only in1[log2(WIDTH)-1:0]; higher bits are ignored.
REQ-018 Add/sub/mul/ACC SHALL wrap modulo 2^WIDTH with no carry or overflow flag.
REQ-019 ACC state SHALL be an accumulator register acc (WIDTH bits) and beat counter cnt (8 bits), with two states: IDLE (cnt=0) and ACCUM (cnt>0).
REQ-020 On an accepted ACC beat with cnt < ACC_LEN-1, acc SHALL become acc+in0, cnt SHALL increment, and out_valid/out0 SHALL be unchanged except that a same-cycle output transfer clears out_valid.
REQ-021 On an accepted ACC beat with cnt = ACC_LEN-1, out0 SHALL become acc+in0, out_valid SHALL become 1, and acc and cnt SHALL clear to 0 (back to IDLE).
REQ-022 With ACC_LEN=1, every ACC beat SHALL output in0 directly.
REQ-023 An accepted non-ACC beat while in ACCUM SHALL discard the partial sum (acc, cnt cleared) and produce its own result normally.
REQ-024 While out_valid=1 and out_ready=0, out0, out_valid, acc and cnt SHALL hold, and no beat is accepted.
REQ-025 Simultaneous output transfer and accepted beat SHALL replace out0 with the new result (out_valid stays 1), or clear out_valid if the beat is a non-final ACC beat.
REQ-026 An output transfer with no accepted beat SHALL clear out_valid and hold out0.

Reset
REQ-027 While reset=1, out0, out_valid, acc and cnt SHALL be 0 at the next edge, in_ready SHALL read 1 after that edge, and no beat is accepted.
REQ-028 Reset asserted mid-accumulation or with a stalled result SHALL discard all state with no output produced.

Verification
REQ-029 Opcode sweep, WIDTH=32, out_ready=1: in0=0xFFFFFFFF, in1=1, op 0 -> out0=0 next cycle; op 10 with in0=0x80000000, in1=4 -> 0xF8000000; op 11 with in0=-1, in1=0 -> 1.
REQ-030 Shift masking: op 6, in0=1, in1=33 -> out0=2.
REQ-031 ACC, ACC_LEN=4: in0=1,2,3,4 on consecutive cycles -> out_valid only after the 4th beat with out0=10; cnt and acc return to 0.
REQ-032 Back-pressure: out_ready=0 after one add result -> in_ready=0, out0 holds for 5 cycles; raising out_ready with a new beat pending -> new result appears on the following edge with no gap.
REQ-033 Abort: two ACC beats (5, 6), then op 0 with in0=1, in1=1 -> out0=2; a following 4-beat ACC of 1s -> out0=4.
REQ-034 Reset mid-ACC after 3 beats, then 4 ACC beats of 1 -> out0=4, not 7.
